// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider.
// State encodings are fixed so the board controller can decode them directly.
// No logic here; types and constants only.
package seq_divider_pkg;

    // Encodings are shared with the controller: IDLE=0, RUN=1, FIN=2.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_sub_stage.sv
// Purpose: W-bit unsigned subtract producing difference and borrow out.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
module div_sub_stage #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);

    // Extend by one bit so the top bit of the result is the borrow.
    assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/seq_divider.sv
// Purpose: iterative radix-2 restoring divider, one quotient bit per clock.
// Latency: start -> done in N+1 cycles, or 1 cycle when divisor is zero.
// Backpressure: start is only accepted while ready=1; ignored in RUN and FIN.
// Optional macro DIV_SIGNED_EN selects two's-complement truncating division.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic             w_accept;
    logic             w_last;
    logic             w_div_zero_in;

    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_q;
    logic [N:0]       r_r;
    logic [N-1:0]     r_dvs;
    logic [N-1:0]     r_quotient;
    logic [N-1:0]     r_remainder;
    logic             r_div_zero;

    logic [N-1:0]     w_dvd_mag;
    logic [N-1:0]     w_dvs_mag;
    logic [N:0]       w_r_shift;
    logic [N:0]       w_diff;
    logic             w_borrow;
    logic [N:0]       w_r_nxt;
    logic [N-1:0]     w_q_nxt;
    logic [N-1:0]     w_quo_fin;
    logic [N-1:0]     w_rem_fin;
    // Partial remainder never exceeds the divisor, so its top bit is never read.
    logic             w_unused;

    assign w_unused      = r_r[N];
    assign w_div_zero_in = (divisor == '0);
    assign w_last        = (r_state == RUN) && (r_cnt == LAST_CNT);

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // Divide magnitudes; the most negative value maps to 2**(N-1), which still fits unsigned.
    assign w_dvd_mag = dividend[N-1] ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = divisor[N-1]  ? (~divisor + 1'b1)  : divisor;
    assign w_quo_fin = r_neg_q ? (~w_q_nxt + 1'b1) : w_q_nxt;
    assign w_rem_fin = r_neg_r ? (~w_r_nxt[N-1:0] + 1'b1) : w_r_nxt[N-1:0];

    // Sign of each result is fixed at accept time; remainder follows the dividend.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= dividend[N-1] ^ divisor[N-1];
            r_neg_r <= dividend[N-1];
        end
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
    assign w_quo_fin = w_q_nxt;
    assign w_rem_fin = w_r_nxt[N-1:0];
`endif

    // One restoring step: shift next dividend bit into R, trial-subtract, keep or restore.
    assign w_r_shift = {r_r[N-1:0], r_q[N-1]};

    div_sub_stage #(.W(N + 1)) u_sub (
        .i_a      (w_r_shift),
        .i_b      ({1'b0, r_dvs}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    assign w_r_nxt = w_borrow ? w_r_shift : w_diff;
    assign w_q_nxt = {r_q[N-2:0], ~w_borrow};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_div_zero_in ? FIN : RUN;
                end
            end
            RUN: begin
                if (w_last) w_state_nxt = FIN;
            end
            FIN: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: load operands on accept, iterate in RUN, publish results on FIN entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_dvs       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_q        <= w_dvd_mag;
            r_r        <= '0;
            r_dvs      <= w_dvs_mag;
            r_div_zero <= w_div_zero_in;
            if (w_div_zero_in) begin
                r_quotient  <= '1;
                r_remainder <= dividend;
            end
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_q   <= w_q_nxt;
            r_r   <= w_r_nxt;
            if (w_last) begin
                r_quotient  <= w_quo_fin;
                r_remainder <= w_rem_fin;
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (N=8): directed cases plus random operands against
// an arithmetic reference model. Honours DIV_SIGNED_EN when defined.
module tb_seq_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         ready;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divider #(.N(N), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // Reference: plain integer division, truncating toward zero when signed.
    task automatic ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output logic [N-1:0] q, output logic [N-1:0] r,
                           output logic dz, output int lat);
        int sa;
        int sb;
        sa = 0;
        sb = 0;
        if (b == 0) begin
            q   = '1;
            r   = a;
            dz  = 1'b1;
            lat = 1;
        end else begin
            dz  = 1'b0;
            lat = N + 1;
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = N'(sa / sb);
            r  = N'(sa % sb);
`else
            sa = int'(a);
            sb = int'(b);
            q  = N'(sa / sb);
            r  = N'(sa % sb);
`endif
        end
    endtask

    // Issue one operation from IDLE (called at posedge+1); returns in the done cycle.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (quotient !== 8'd0) begin failures++; $display("FAIL reset_quotient got %0d exp 0", quotient); end
        checks++; if (remainder !== 8'd0) begin failures++; $display("FAIL reset_remainder got %0d exp 0", remainder); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got %b exp 0", div_zero); end
    endtask

    task automatic test_directed;
        logic [N-1:0] a_tab [4] = '{8'd100, 8'd5, 8'd200, 8'd3};
        logic [N-1:0] b_tab [4] = '{8'd7,   8'd0, 8'd200, 8'd10};
        logic [N-1:0] eq, er;
        logic         edz;
        int           elat, lat;
        for (int i = 0; i < 4; i++) begin
            ref_div(a_tab[i], b_tab[i], eq, er, edz, elat);
            run_op(a_tab[i], b_tab[i], lat);
            checks++; if (lat != elat) begin failures++; $display("FAIL directed_latency[%0d] got %0d exp %0d", i, lat, elat); end
            checks++; if ({quotient, remainder, div_zero} !== {eq, er, edz})
                begin failures++; $display("FAIL directed_result[%0d] got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b", i, quotient, remainder, div_zero, eq, er, edz); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignored_start;
        logic [N-1:0] eq, er;
        logic         edz;
        int           elat, lat;
        ref_div(8'd100, 8'd7, eq, er, edz, elat);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            start    = (lat == 3 || lat == 5);
            dividend = 8'd201;
            divisor  = 8'd3;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        checks++; if (lat != elat) begin failures++; $display("FAIL ignore_latency got %0d exp %0d", lat, elat); end
        checks++; if ({quotient, remainder, div_zero} !== {eq, er, edz})
            begin failures++; $display("FAIL ignore_result got q=%0d r=%0d exp q=%0d r=%0d", quotient, remainder, eq, er); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(8'd255, 8'd1, lat);
        checks++; if ({quotient, remainder} !== {8'd255, 8'd0})
            begin failures++; $display("FAIL b2b_first got q=%0d r=%0d exp q=255 r=0", quotient, remainder); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_fin_ready got %b exp 0", ready); end
        start = 1'b1; dividend = 8'd3; divisor = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_fin_start_ignored ready got %b exp 1", ready); end
        run_op(8'd7, 8'd9, lat);
        checks++; if (lat != N + 1) begin failures++; $display("FAIL b2b_latency got %0d exp %0d", lat, N + 1); end
        checks++; if ({quotient, remainder, div_zero} !== {8'd0, 8'd7, 1'b0})
            begin failures++; $display("FAIL b2b_second got q=%0d r=%0d dz=%b exp q=0 r=7 dz=0", quotient, remainder, div_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        run_op(8'd5, 8'd0, lat);
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (lat < 4) begin @(posedge clk); #1; lat++; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got %b exp 1", ready); end
        checks++; if ({quotient, remainder, div_zero} !== {8'd0, 8'd0, 1'b0})
            begin failures++; $display("FAIL midreset_outputs got q=%0d r=%0d dz=%b exp 0 0 0", quotient, remainder, div_zero); end
        seen = 0;
        for (int i = 0; i < N + 3; i++) begin
            if (done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midreset_no_done got %0d pulses exp 0", seen); end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed;
        int lat;
        run_op(8'h9C, 8'd7, lat);
        checks++; if ({quotient, remainder} !== {8'hF2, 8'hFE})
            begin failures++; $display("FAIL signed_neg100_7 got q=%h r=%h exp q=f2 r=fe", quotient, remainder); end
        @(posedge clk); #1;
        run_op(8'h80, 8'hFF, lat);
        checks++; if ({quotient, remainder, div_zero} !== {8'h80, 8'h00, 1'b0})
            begin failures++; $display("FAIL signed_min_neg1 got q=%h r=%h dz=%b exp q=80 r=00 dz=0", quotient, remainder, div_zero); end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_random;
        logic [N-1:0] a, b, eq, er;
        logic         edz;
        int           elat, lat;
        for (int i = 0; i < 60; i++) begin
            a = N'($urandom);
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = 8'd1;
                2:       b = N'($urandom_range(1, 15));
                default: b = N'($urandom);
            endcase
            ref_div(a, b, eq, er, edz, elat);
            run_op(a, b, lat);
            checks++; if (lat != elat) begin failures++; $display("FAIL rand_latency[%0d] %0d/%0d got %0d exp %0d", i, a, b, lat, elat); end
            checks++; if ({quotient, remainder, div_zero} !== {eq, er, edz})
                begin failures++; $display("FAIL rand_result[%0d] %0d/%0d got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b", i, a, b, quotient, remainder, div_zero, eq, er, edz); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
